// File: rtl/multi_zone_light_ctrl.sv
// Multi-zone lighting controller: per-zone OFF/MANUAL/AUTO_ON/HOLD FSM,
// occupancy hold timer, optional soft fade and a shared PWM output stage.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   app_switch      per-zone manual override (highest priority)
//   movement        per-zone occupancy sensor
//   dark            global ambient-dark flag
//   room_intensity  packed per-zone target level (zone z at [z*LVL_W +: LVL_W])
//   hold_cycles     occupancy hold time, sampled on entry to HOLD
//   light_control   per-zone registered PWM drive
//   zone_state      packed per-zone state (3 bits each, 0..3)
//   level           packed per-zone applied level
//
// Build option: define SOFT_FADE_EN to ramp level by 1 per cycle
// toward the target instead of loading it directly.
module multi_zone_light_ctrl #(
   parameter int NUM_ZONES = 4,
   parameter int LVL_W     = 8,
   parameter int HOLD_W    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_ZONES-1:0]         app_switch,
   input  logic [NUM_ZONES-1:0]         movement,
   input  logic                         dark,
   input  logic [NUM_ZONES*LVL_W-1:0]   room_intensity,
   input  logic [HOLD_W-1:0]            hold_cycles,
   output logic [NUM_ZONES-1:0]         light_control,
   output logic [NUM_ZONES*3-1:0]       zone_state,
   output logic [NUM_ZONES*LVL_W-1:0]   level
);

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      MANUAL  = 2'd1,
      AUTO_ON = 2'd2,
      HOLD    = 2'd3
   } state_e;

   logic [LVL_W-1:0] pwm_q;

   // One counter shared by all zones keeps their PWM phases aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm_q <= '0;
      else     pwm_q <= pwm_q + LVL_W'(1);
   end

   for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
      state_e           state_q;
      logic [HOLD_W-1:0] timer_q;
      logic [LVL_W-1:0] level_q;
      logic [LVL_W-1:0] level_d;
      logic [LVL_W-1:0] target;
      logic             light_q;

      // Target follows room_intensity live in every lit state.
      assign target = (state_q == OFF) ? '0
                    : room_intensity[z*LVL_W +: LVL_W];

      always_comb begin
         level_d = target;
`ifdef SOFT_FADE_EN
         if (level_q < target)
            level_d = level_q + LVL_W'(1);
         else if (level_q > target)
            level_d = level_q - LVL_W'(1);
         else
            level_d = level_q;
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= OFF;
            timer_q <= '0;
         end else if (app_switch[z]) begin
            state_q <= MANUAL;
         end else begin
            unique case (state_q)
               OFF, MANUAL: begin
                  state_q <= (movement[z] & dark) ? AUTO_ON : OFF;
               end
               AUTO_ON: begin
                  if (!dark) begin
                     state_q <= OFF;
                  end else if (!movement[z]) begin
                     if (hold_cycles == '0) begin
                        state_q <= OFF;
                     end else begin
                        timer_q <= hold_cycles;
                        state_q <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  // Timer value N on entry gives exactly N cycles in HOLD.
                  if (!dark)
                     state_q <= OFF;
                  else if (movement[z])
                     state_q <= AUTO_ON;
                  else if (timer_q == HOLD_W'(1))
                     state_q <= OFF;
                  else
                     timer_q <= timer_q - HOLD_W'(1);
               end
            endcase
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            level_q <= '0;
            light_q <= 1'b0;
         end else begin
            level_q <= level_d;
            light_q <= (pwm_q < level_q);
         end
      end

      assign zone_state[z*3 +: 3]       = {1'b0, state_q};
      assign level[z*LVL_W +: LVL_W]    = level_q;
      assign light_control[z]           = light_q;
   end

endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// Testbench for multi_zone_light_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural reference model.
module tb_multi_zone_light_ctrl;

   localparam int NZ = 4;
   localparam int LW = 8;
   localparam int HW = 16;

   localparam int ST_OFF  = 0;
   localparam int ST_MAN  = 1;
   localparam int ST_AUTO = 2;
   localparam int ST_HOLD = 3;

`ifdef SOFT_FADE_EN
   localparam int FADE = 1;
`else
   localparam int FADE = 0;
`endif

   logic              clk;
   logic              rst;
   logic [NZ-1:0]     app_switch;
   logic [NZ-1:0]     movement;
   logic              dark;
   logic [NZ*LW-1:0]  room_intensity;
   logic [HW-1:0]     hold_cycles;
   logic [NZ-1:0]     light_control;
   logic [NZ*3-1:0]   zone_state;
   logic [NZ*LW-1:0]  level;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int          m_st[NZ];
   int          m_tm[NZ];
   int          m_lv[NZ];
   int          m_pwm;
   logic [NZ-1:0] m_lc;

   multi_zone_light_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .app_switch     (app_switch),
      .movement       (movement),
      .dark           (dark),
      .room_intensity (room_intensity),
      .hold_cycles    (hold_cycles),
      .light_control  (light_control),
      .zone_state     (zone_state),
      .level          (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      for (int z = 0; z < NZ; z++) begin
         m_st[z] = ST_OFF;
         m_tm[z] = 0;
         m_lv[z] = 0;
      end
      m_pwm = 0;
      m_lc  = '0;
   endtask

   task automatic model_step();
      int tgt;
      for (int z = 0; z < NZ; z++) begin
         tgt = (m_st[z] == ST_OFF) ? 0
             : int'(room_intensity[z*LW +: LW]);
         m_lc[z] = (m_pwm < m_lv[z]);
         if (FADE != 0) begin
            if (m_lv[z] < tgt)      m_lv[z]++;
            else if (m_lv[z] > tgt) m_lv[z]--;
         end else begin
            m_lv[z] = tgt;
         end
         if (app_switch[z]) begin
            m_st[z] = ST_MAN;
         end else begin
            case (m_st[z])
               ST_OFF, ST_MAN:
                  m_st[z] = (movement[z] && dark) ? ST_AUTO : ST_OFF;
               ST_AUTO:
                  if (!dark) m_st[z] = ST_OFF;
                  else if (!movement[z]) begin
                     if (hold_cycles == 0) m_st[z] = ST_OFF;
                     else begin
                        m_tm[z] = int'(hold_cycles);
                        m_st[z] = ST_HOLD;
                     end
                  end
               ST_HOLD:
                  if (!dark) m_st[z] = ST_OFF;
                  else if (movement[z]) m_st[z] = ST_AUTO;
                  else if (m_tm[z] == 1) m_st[z] = ST_OFF;
                  else m_tm[z]--;
               default: m_st[z] = ST_OFF;
            endcase
         end
      end
      m_pwm = (m_pwm + 1) % (1 << LW);
   endtask

   function automatic logic [NZ*3-1:0] exp_zs();
      logic [NZ*3-1:0] r;
      for (int z = 0; z < NZ; z++) r[z*3 +: 3] = 3'(m_st[z]);
      return r;
   endfunction

   function automatic logic [NZ*LW-1:0] exp_lv();
      logic [NZ*LW-1:0] r;
      for (int z = 0; z < NZ; z++) r[z*LW +: LW] = LW'(m_lv[z]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      app_switch = '0;
      movement   = '0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      app_switch     = '0;
      movement       = '0;
      dark           = 1'b0;
      room_intensity = '0;
      hold_cycles    = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      n_chk++;
      if (zone_state !== '0) begin
         n_fail++;
         $display("FAIL reset_state got %h want 0", zone_state);
      end
      n_chk++;
      if (level !== '0) begin
         n_fail++;
         $display("FAIL reset_level got %h want 0", level);
      end
      n_chk++;
      if (light_control !== '0) begin
         n_fail++;
         $display("FAIL reset_light got %b want 0", light_control);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_manual();
      int cyc;
      int hi;
      int lat;
      lat = (FADE != 0) ? 128 : 1;
      dark = 1'b0;
      movement = '0;
      room_intensity[0 +: LW] = 8'd128;
      app_switch = 4'b0001;
      tick();
      n_chk++;
      if (zone_state[2:0] !== 3'd1) begin
         n_fail++;
         $display("FAIL manual_enter got %0d want 1", zone_state[2:0]);
      end
      cyc = 0;
      while (level[0 +: LW] !== 8'd128 && cyc < 400) begin
         tick();
         cyc++;
      end
      n_chk++;
      if (cyc != lat) begin
         n_fail++;
         $display("FAIL manual_level_latency got %0d want %0d", cyc, lat);
      end
      tick();
      hi = 0;
      repeat (256) begin
         tick();
         hi += int'(light_control[0]);
      end
      n_chk++;
      if (hi != 128) begin
         n_fail++;
         $display("FAIL manual_pwm_duty got %0d want 128", hi);
      end
      app_switch = '0;
      tick();
      n_chk++;
      if (zone_state[2:0] !== 3'd0) begin
         n_fail++;
         $display("FAIL manual_release got %0d want 0", zone_state[2:0]);
      end
      cyc = 0;
      while (level[0 +: LW] !== 8'd0 && cyc < 400) begin
         tick();
         cyc++;
      end
      n_chk++;
      if (cyc != lat) begin
         n_fail++;
         $display("FAIL manual_off_latency got %0d want %0d", cyc, lat);
      end
   endtask

   task automatic test_hold_timeout();
      int hc;
      dark = 1'b1;
      room_intensity[LW +: LW] = 8'd200;
      hold_cycles = 16'd10;
      movement = 4'b0010;
      tick();
      n_chk++;
      if (zone_state[5:3] !== 3'd2) begin
         n_fail++;
         $display("FAIL hold_auto got %0d want 2", zone_state[5:3]);
      end
      repeat (3) tick();
      movement = '0;
      tick();
      n_chk++;
      if (zone_state[5:3] !== 3'd3) begin
         n_fail++;
         $display("FAIL hold_enter got %0d want 3", zone_state[5:3]);
      end
      // Changing hold_cycles now must not affect this HOLD period.
      hold_cycles = 16'd3;
      hc = 1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (zone_state[5:3] === 3'd3) hc++;
         else break;
      end
      n_chk++;
      if (hc != 10) begin
         n_fail++;
         $display("FAIL hold_length got %0d want 10", hc);
      end
      n_chk++;
      if (zone_state[5:3] !== 3'd0) begin
         n_fail++;
         $display("FAIL hold_exit got %0d want 0", zone_state[5:3]);
      end
   endtask

   task automatic test_daylight();
      idle(300);
      dark = 1'b0;
      movement = 4'b1111;
      room_intensity = {4{8'd255}};
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++;
         if (zone_state !== '0 || light_control !== '0) begin
            n_fail++;
            $display("FAIL daylight_off cyc %0d got %h/%b want 0/0",
                     i, zone_state, light_control);
         end
      end
      dark = 1'b1;
      tick();
      n_chk++;
      if (zone_state !== {4{3'd2}}) begin
         n_fail++;
         $display("FAIL daylight_auto got %h want %h",
                  zone_state, {4{3'd2}});
      end
      hold_cycles = 16'd20;
      movement = '0;
      tick();
      n_chk++;
      if (zone_state !== {4{3'd3}}) begin
         n_fail++;
         $display("FAIL daylight_hold got %h want %h",
                  zone_state, {4{3'd3}});
      end
      repeat (3) tick();
      dark = 1'b0;
      tick();
      n_chk++;
      if (zone_state !== '0) begin
         n_fail++;
         $display("FAIL daylight_drop got %h want 0", zone_state);
      end
   endtask

   task automatic test_priority();
      int hc;
      idle(2);
      dark = 1'b1;
      hold_cycles = 16'd5;
      room_intensity[2*LW +: LW] = 8'd100;
      room_intensity[3*LW +: LW] = 8'd150;
      app_switch = 4'b0100;
      movement   = 4'b1100;
      tick();
      n_chk++;
      if (zone_state[8:6] !== 3'd1 || zone_state[11:9] !== 3'd2) begin
         n_fail++;
         $display("FAIL prio_concurrent got z2=%0d z3=%0d want 1/2",
                  zone_state[8:6], zone_state[11:9]);
      end
      movement = '0;
      hc = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         n_chk++;
         if (zone_state[8:6] !== 3'd1) begin
            n_fail++;
            $display("FAIL prio_z2_hold cyc %0d got %0d want 1",
                     i, zone_state[8:6]);
         end
         if (zone_state[11:9] === 3'd3) hc++;
      end
      n_chk++;
      if (hc != 5 || zone_state[11:9] !== 3'd0) begin
         n_fail++;
         $display("FAIL prio_z3_timeout got hold=%0d st=%0d want 5/0",
                  hc, zone_state[11:9]);
      end
      n_chk++;
      if (zone_state !== exp_zs() || level !== exp_lv()) begin
         n_fail++;
         $display("FAIL prio_model got %h/%h want %h/%h",
                  zone_state, level, exp_zs(), exp_lv());
      end
      app_switch = '0;
   endtask

   task automatic test_async_reset();
      dark = 1'b1;
      room_intensity = {8'd10, 8'd200, 8'd20, 8'd255};
      app_switch = 4'b0001;
      movement = '0;
      repeat (300) tick();
      hold_cycles = 16'd50;
      movement = 4'b0010;
      repeat (2) tick();
      movement = '0;
      repeat (4) tick();
      n_chk++;
      if (zone_state[5:3] !== 3'd3 || level === '0) begin
         n_fail++;
         $display("FAIL areset_setup got st=%0d lv=%h want 3/nonzero",
                  zone_state[5:3], level);
      end
      app_switch = '0;
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (zone_state !== '0 || level !== '0 || light_control !== '0) begin
         n_fail++;
         $display("FAIL areset_immediate got %h/%h/%b want 0/0/0",
                  zone_state, level, light_control);
      end
      #1 rst = 1'b0;
      model_reset();
      repeat (3) tick();
      n_chk++;
      if (zone_state !== '0 || level !== exp_lv()
          || light_control !== m_lc) begin
         n_fail++;
         $display("FAIL areset_restart got %h/%h/%b want 0/%h/%b",
                  zone_state, level, light_control, exp_lv(), m_lc);
      end
   endtask

`ifdef SOFT_FADE_EN
   task automatic test_fade();
      int cyc;
      int prev;
      idle(300);
      dark = 1'b0;
      room_intensity[0 +: LW] = 8'd64;
      app_switch = 4'b0001;
      tick();
      cyc = 0;
      prev = 0;
      while (level[0 +: LW] !== 8'd64 && cyc < 300) begin
         tick();
         cyc++;
         n_chk++;
         if (int'(level[0 +: LW]) != prev + 1) begin
            n_fail++;
            $display("FAIL fade_step got %0d want %0d",
                     level[0 +: LW], prev + 1);
         end
         prev = int'(level[0 +: LW]);
      end
      n_chk++;
      if (cyc != 64) begin
         n_fail++;
         $display("FAIL fade_0_64 got %0d want 64", cyc);
      end
      app_switch = '0;
      repeat (80) tick();
      app_switch = 4'b0001;
      cyc = 0;
      while (level[0 +: LW] !== 8'd40 && cyc < 100) begin
         tick();
         cyc++;
      end
      room_intensity[0 +: LW] = 8'd32;
      tick();
      n_chk++;
      if (level[0 +: LW] !== 8'd39) begin
         n_fail++;
         $display("FAIL fade_reverse got %0d want 39", level[0 +: LW]);
      end
      repeat (12) tick();
      n_chk++;
      if (level[0 +: LW] !== 8'd32) begin
         n_fail++;
         $display("FAIL fade_settle got %0d want 32", level[0 +: LW]);
      end
      app_switch = '0;
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         for (int z = 0; z < NZ; z++) begin
            app_switch[z] = ($urandom_range(7) == 0);
            if ($urandom_range(3) == 0) movement[z] = ~movement[z];
            if ($urandom_range(15) == 0)
               room_intensity[z*LW +: LW] = LW'($urandom);
         end
         if ($urandom_range(19) == 0) dark = ~dark;
         if ($urandom_range(3) == 0)
            hold_cycles = HW'($urandom_range(7));
         if ($urandom_range(199) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
            model_reset();
         end
         tick();
         n_chk++;
         if (zone_state !== exp_zs()) begin
            n_fail++;
            $display("FAIL rand_state cyc %0d got %h want %h",
                     c, zone_state, exp_zs());
         end
         n_chk++;
         if (level !== exp_lv()) begin
            n_fail++;
            $display("FAIL rand_level cyc %0d got %h want %h",
                     c, level, exp_lv());
         end
         n_chk++;
         if (light_control !== m_lc) begin
            n_fail++;
            $display("FAIL rand_light cyc %0d got %b want %b",
                     c, light_control, m_lc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_hold_timeout();
      test_daylight();
      test_priority();
      test_async_reset();
`ifdef SOFT_FADE_EN
      test_fade();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
